// File: rtl/hack_pkg.sv
// Shared definitions for Hack-word datapath blocks: word width and a
// select-width helper that stays at least one bit wide for tiny channel counts.
package hack_pkg;

  localparam int HACK_WORD_W = 16;

  // Width of an index able to name n items; never returns zero.
  function automatic int selw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter used by stream_mux when STREAM_MUX_RR_EN is defined.
// Searches from ptr+1 upward with wrap-around; the pointer moves to the
// granted index only when advance is strobed.
module rr_arbiter
  import hack_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = selw_f(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;

  // Pick the first requester after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = SELW'(j);
      end
    end
  end

  // Pointer follows the winner only on an accepted transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && any) ptr_d = grant_idx;
  end

  // Reset pointer to the last channel so channel 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= SELW'(NCH - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stream_mux.sv
// Registered NCH-channel stream multiplexer with valid/ready handshakes.
// Selects one channel per transfer via sel, or round-robin when the build
// defines STREAM_MUX_RR_EN and rr_mode is high. One-entry output register.
module stream_mux
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W,
  parameter int NCH   = 4,
  parameter int SELW  = selw_f(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      sel,
  input  logic                 rr_mode,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;

  logic [NCH-1:0]   sel_hit;
  logic [NCH-1:0]   win_oh;
  logic             can_load;
  logic             xfer;
  logic             rr_active;
  logic [WIDTH-1:0] load_data;
  logic [SELW-1:0]  load_ch;

  // Decode sel into a one-hot; an out-of-range sel yields no winner.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sel_dec
      assign sel_hit[gi] = (sel == SELW'(gi));
    end
  endgenerate

`ifdef STREAM_MUX_RR_EN
  logic [NCH-1:0]  rr_grant;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;

  assign rr_active = rr_mode;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (xfer && rr_active),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // rr_idx/rr_any are implied by the one-hot grant; kept for other users.
  logic unused_rr;
  assign unused_rr = ^{rr_idx, rr_any};
  assign win_oh    = rr_active ? rr_grant : sel_hit;
`else
  // rr_mode is kept only for interface stability in sel-only builds.
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;
  assign rr_active      = 1'b0;
  assign win_oh         = sel_hit;
`endif

  assign can_load = (state_q == ST_EMPTY) || out_ready;
  assign in_ready = {NCH{can_load}} & win_oh;
  assign xfer     = |(in_valid & in_ready);

  // Steer the winning channel's word and index toward the output register.
  always_comb begin
    load_data = '0;
    load_ch   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win_oh[i]) begin
        load_data = in_data[i*WIDTH +: WIDTH];
        load_ch   = SELW'(i);
      end
    end
  end

  // Output stage: load on transfer (also while draining), empty on drain alone.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (xfer) begin
      state_d = ST_FULL;
      data_d  = load_data;
      ch_d    = load_ch;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Output register; reset discards any buffered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
